// File: rtl/mpc_sequencer.sv
// mpc_sequencer: microprogram sequencer owning MPC, N/Z flags, memory-wait/halt sequencing and a retired-microinstruction counter.
module mpc_sequencer #(
  parameter int ADDR_W     = 9,
  parameter int MBR_W      = 8,
  parameter int RESET_ADDR = 0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] NEXT_ADDR,
  input  logic              JAMN,
  input  logic              JAMZ,
  input  logic              JMPC,
  input  logic              N_in,
  input  logic              Z_in,
  input  logic              flag_en,
  input  logic [MBR_W-1:0]  MBR,
  input  logic              mem_rd,
  input  logic              mem_fetch,
  input  logic              mem_ready,
  input  logic              halt,
  output logic [ADDR_W-1:0] MPC,
  output logic              mpc_valid,
  output logic              stall,
  output logic              N_ff,
  output logic              Z_ff,
  output logic [CNT_W-1:0]  ucount
);
  typedef enum logic [1:0] {RUN, WAIT, HALT} state_t;
  state_t state, state_nxt;
  logic eff_n, eff_z, req, advance;
  logic [ADDR_W-1:0] next;
  always_comb begin
    eff_n = flag_en ? N_in : N_ff;
    eff_z = flag_en ? Z_in : Z_ff;
    req = mem_rd | mem_fetch;
    next = {NEXT_ADDR[ADDR_W-1] | (JAMN & eff_n) | (JAMZ & eff_z), NEXT_ADDR[MBR_W-1:0] | (JMPC ? MBR : '0)};
    advance = (state == RUN && !halt && (!req || mem_ready)) || (state == WAIT && mem_ready);
    stall = !reset && !advance;
    state_nxt = state == RUN ? (halt ? HALT : (req && !mem_ready) ? WAIT : RUN) :
                state == WAIT ? (mem_ready ? RUN : WAIT) :
                (halt ? HALT : RUN);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      MPC <= ADDR_W'(RESET_ADDR);
      N_ff <= 1'b0;
      Z_ff <= 1'b0;
      ucount <= '0;
      state <= RUN;
      mpc_valid <= 1'b1;
    end else begin
      if (advance) begin
        MPC <= next;
        ucount <= ucount + 1'b1;
        if (flag_en) begin
          N_ff <= N_in;
          Z_ff <= Z_in;
        end
      end
      state <= state_nxt;
      mpc_valid <= state_nxt != HALT;
    end
  end
endmodule

// File: tb/tb_mpc_sequencer.sv
// tb_mpc_sequencer: directed stimulus with a per-cycle behavioural model compare plus literal pins.
module tb_mpc_sequencer;
  logic clk = 0, reset = 1;
  logic [8:0] NEXT_ADDR = 0;
  logic JAMN = 0, JAMZ = 0, JMPC = 0, N_in = 0, Z_in = 0, flag_en = 0;
  logic [7:0] MBR = 0;
  logic mem_rd = 0, mem_fetch = 0, mem_ready = 0, halt = 0;
  logic [8:0] MPC;
  logic mpc_valid, stall, N_ff, Z_ff;
  logic [15:0] ucount;
  int n_chk = 0, n_fail = 0;
  int m_mpc, m_cnt;
  bit m_n, m_z, m_halted, m_pending, started = 0, e_n, e_z;

  mpc_sequencer dut (.clk(clk), .reset(reset), .NEXT_ADDR(NEXT_ADDR), .JAMN(JAMN), .JAMZ(JAMZ),
    .JMPC(JMPC), .N_in(N_in), .Z_in(Z_in), .flag_en(flag_en), .MBR(MBR), .mem_rd(mem_rd),
    .mem_fetch(mem_fetch), .mem_ready(mem_ready), .halt(halt), .MPC(MPC), .mpc_valid(mpc_valid),
    .stall(stall), .N_ff(N_ff), .Z_ff(Z_ff), .ucount(ucount));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit can_adv();
    if (m_halted) return 0;
    if (m_pending) return mem_ready;
    return !halt && (!(mem_rd || mem_fetch) || mem_ready);
  endfunction

  // Model: a microinstruction retires when memory permits and no halt is in force.
  always @(posedge clk) begin
    if (reset) begin
      m_mpc = 0; m_cnt = 0; m_n = 0; m_z = 0; m_halted = 0; m_pending = 0; started = 1;
    end else if (can_adv()) begin
      e_n = flag_en ? N_in : m_n;
      e_z = flag_en ? Z_in : m_z;
      m_mpc = int'(NEXT_ADDR) | (JMPC ? int'(MBR) : 0) | (((JAMN && e_n) || (JAMZ && e_z)) ? 256 : 0);
      if (flag_en) begin m_n = N_in; m_z = Z_in; end
      m_cnt = (m_cnt + 1) % 65536;
      m_pending = 0;
    end else if (m_halted) m_halted = halt;
    else if (!m_pending) begin
      if (halt) m_halted = 1;
      else m_pending = 1;
    end
  end

  always @(negedge clk) if (started) begin
    chk("mpc", 32'(MPC), m_mpc);
    chk("mpc_valid", 32'(mpc_valid), 32'(!m_halted));
    chk("n_ff", 32'(N_ff), 32'(m_n));
    chk("z_ff", 32'(Z_ff), 32'(m_z));
    chk("ucount", 32'(ucount), m_cnt);
    chk("stall", 32'(stall), reset ? 0 : 32'(!can_adv()));
  end

  task automatic cyc(); @(posedge clk); #1; endtask
  task automatic idle();
    reset = 0; NEXT_ADDR = 0; JAMN = 0; JAMZ = 0; JMPC = 0; N_in = 0; Z_in = 0; flag_en = 0;
    MBR = 0; mem_rd = 0; mem_fetch = 0; mem_ready = 0; halt = 0;
  endtask

  initial begin
    reset = 1; NEXT_ADDR = 9'h1FF; JAMZ = 1; Z_in = 1; flag_en = 1;
    cyc(); cyc();
    chk("rst_mpc", 32'(MPC), 0); chk("rst_nz", 32'({N_ff, Z_ff}), 0);
    chk("rst_cnt", 32'(ucount), 0); chk("rst_valid", 32'(mpc_valid), 1);
    idle();
    #1 chk("rst_stall", 32'(stall), 0);
    NEXT_ADDR = 9'h012; JAMZ = 1; flag_en = 1; Z_in = 1; cyc();
    chk("jamz1", 32'(MPC), 32'h112); chk("jamz1_z", 32'(Z_ff), 1);
    Z_in = 0; cyc();
    chk("jamz0", 32'(MPC), 32'h012); chk("cnt2", 32'(ucount), 2);
    idle(); flag_en = 1; N_in = 1; NEXT_ADDR = 9'h001; cyc();
    idle(); JAMN = 1; NEXT_ADDR = 9'h040; cyc();
    chk("jamn_latched", 32'(MPC), 32'h140);
    NEXT_ADDR = 9'h1C0; cyc();
    chk("jamn_hi", 32'(MPC), 32'h1C0);
    idle(); NEXT_ADDR = 9'h100; JMPC = 1; MBR = 8'h3C; cyc();
    chk("jmpc1", 32'(MPC), 32'h13C); chk("cnt6", 32'(ucount), 6);
    MBR = 8'hFF; NEXT_ADDR = 9'h0F0; cyc();
    chk("jmpc2", 32'(MPC), 32'h0FF);
    idle(); mem_fetch = 1; NEXT_ADDR = 9'h020;
    repeat (3) begin
      cyc();
      chk("wait_mpc", 32'(MPC), 32'h0FF); chk("wait_stall", 32'(stall), 1);
      chk("wait_valid", 32'(mpc_valid), 1);
    end
    mem_ready = 1; cyc();
    chk("wait_done", 32'(MPC), 32'h020); chk("wait_cnt", 32'(ucount), 8);
    idle(); mem_rd = 1; NEXT_ADDR = 9'h030; cyc();
    halt = 1; cyc();
    chk("wait_halt_ign", 32'(mpc_valid), 1);
    mem_ready = 1; cyc();
    chk("wait_halt_adv", 32'(MPC), 32'h030);
    mem_rd = 0; mem_ready = 0; cyc();
    chk("halt_valid", 32'(mpc_valid), 0);
    repeat (4) cyc();
    chk("halt_mpc", 32'(MPC), 32'h030); chk("halt_cnt", 32'(ucount), 9);
    halt = 0; NEXT_ADDR = 9'h055; cyc();
    chk("unhalt_mpc", 32'(MPC), 32'h030); chk("unhalt_valid", 32'(mpc_valid), 1);
    cyc();
    chk("unhalt_exec", 32'(MPC), 32'h055); chk("cnt10", 32'(ucount), 10);
    idle(); mem_rd = 1; NEXT_ADDR = 9'h0AA; cyc();
    reset = 1; cyc();
    idle();
    #1 chk("rstw_mpc", 32'(MPC), 0); chk("rstw_stall", 32'(stall), 0);
    cyc();
    chk("rstw_run", 32'(ucount), 1);
    mem_ready = 1; NEXT_ADDR = 9'h007; cyc();
    chk("stray_ready", 32'(MPC), 32'h007);
    idle(); mem_fetch = 1; JMPC = 1; NEXT_ADDR = 9'h100; MBR = 8'h11; cyc();
    MBR = 8'h22; mem_ready = 1; cyc();
    chk("fetch_mbr", 32'(MPC), 32'h122);
    idle();
    repeat (65532) cyc();
    chk("cnt_max", 32'(ucount), 32'hFFFF);
    cyc();
    chk("cnt_wrap", 32'(ucount), 0);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
